// File: rtl/xm23_int_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : xm23_int_ctrl_if
//  Description : Request/acknowledge handshake between the XM-23 priority
//                interrupt controller and the control unit. The controller
//                presents {valid, vector, priority} on pic_in. The control
//                unit returns pic_read and the current CPU priority.
//  Revision    : 1.0 - initial release
// ============================================================================
interface xm23_int_ctrl_if;
    logic [7:0] pic_in;     // [7] valid, [6:3] vector, [2:0] device priority
    logic       pic_read;   // control-unit acknowledge of the presented request
    logic [2:0] cpu_pri;    // PSW[7:5]

    // Interrupt controller side
    modport master (
        output pic_in,
        input  pic_read,
        input  cpu_pri
    );

    // Control-unit side
    modport slave (
        input  pic_in,
        output pic_read,
        output cpu_pri
    );
endinterface
`default_nettype wire

// File: rtl/xm23_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : xm23_int_ctrl
//  Description : Priority interrupt controller for the XM-23 control unit.
//                It watches the CSR bytes of the five memory-mapped devices
//                and latches rising request edges. It arbitrates pending,
//                eligible devices against the CPU priority and presents one
//                registered request on pic_in. That request is held until
//                the control unit acknowledges it or the request becomes
//                stale. All state advances on the falling clock edge, which
//                matches the CPU bus mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module xm23_int_ctrl #(
    parameter logic [3:0] VEC_BASE = 4'd0,   // vector of device 0
    parameter int         NUM_DEV  = 5       // 0 tmr, 1 kb, 2 scr, 3 tl, 4 pb
) (
    input  wire logic               Clock,
    input  wire logic               Reset,
    input  wire logic [7:0]         csr_tmr,
    input  wire logic [7:0]         csr_kb,
    input  wire logic [7:0]         csr_scr,
    input  wire logic [7:0]         csr_tl,
    input  wire logic [7:0]         csr_pb,
    xm23_int_ctrl_if.master         bus,
    output logic [NUM_DEV-1:0]      int_pending
);

    localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        ACK     = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Device CSR decode
    // ------------------------------------------------------------------
    logic [7:0]         w_csr [NUM_DEV];
    logic [2:0]         w_dev_pri [NUM_DEV];
    logic [NUM_DEV-1:0] w_req;
    logic [NUM_DEV-1:0] w_elig;
    logic [NUM_DEV-1:0] w_unused_csr_bits;

    logic [NUM_DEV-1:0] r_prev;
    logic [NUM_DEV-1:0] r_pend;
    logic [NUM_DEV-1:0] w_pend_nxt;
    logic [NUM_DEV-1:0] w_rise;
    logic [NUM_DEV-1:0] w_ack_clr;

    // Map the fixed device ports onto an indexed array. Any device slots
    // beyond the five physical devices read as idle.
    generate
        for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_csr
            if (gi == 0) begin : g_tmr
                assign w_csr[gi] = csr_tmr;
            end else if (gi == 1) begin : g_kb
                assign w_csr[gi] = csr_kb;
            end else if (gi == 2) begin : g_scr
                assign w_csr[gi] = csr_scr;
            end else if (gi == 3) begin : g_tl
                assign w_csr[gi] = csr_tl;
            end else if (gi == 4) begin : g_pb
                assign w_csr[gi] = csr_pb;
            end else begin : g_none
                assign w_csr[gi] = 8'h00;
            end
        end
    endgenerate

    // Per-device request level, priority and eligibility. CSR bits 1 and 4
    // carry no interrupt meaning.
    generate
        for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_dev
            assign w_req[gi]             = w_csr[gi][0] & (w_csr[gi][2] | w_csr[gi][3]);
            assign w_dev_pri[gi]         = w_csr[gi][7:5];
            assign w_elig[gi]            = r_pend[gi] & (w_dev_pri[gi] > bus.cpu_pri);
            assign w_unused_csr_bits[gi] = w_csr[gi][1] ^ w_csr[gi][4];
        end
    endgenerate

    // A rising edge sets pend. This takes precedence over an acknowledge
    // in the same cycle. A low request level drops pend.
    assign w_rise     = w_req & ~r_prev;
    assign w_pend_nxt = w_rise | (r_pend & w_req & ~w_ack_clr);

    // Edge detector history and pending latches
    always_ff @(negedge Clock or posedge Reset) begin
        if (Reset) begin
            r_prev <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= w_req;
            r_pend <= w_pend_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration: highest device priority wins; on a tie the strict
    // compare keeps the lowest index found first.
    // ------------------------------------------------------------------
    logic             w_any;
    logic [IDX_W-1:0] w_win_idx;
    logic [2:0]       w_win_pri;

    // Combinational priority search over eligible devices
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = '0;
        w_win_pri = 3'd0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (w_elig[i] && (!w_any || (w_dev_pri[i] > w_win_pri))) begin
                w_any     = 1'b1;
                w_win_idx = IDX_W'(i);
                w_win_pri = w_dev_pri[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_pic_in;
    logic [7:0]       w_pic_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [2:0]       r_pri;
    logic [2:0]       w_pri_nxt;

    // Next state, next registered request and acknowledge clear
    always_comb begin
        w_state_nxt = r_state;
        w_pic_nxt   = 8'h00;
        w_idx_nxt   = r_idx;
        w_pri_nxt   = r_pri;
        w_ack_clr   = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = PRESENT;
                    w_idx_nxt   = w_win_idx;
                    w_pri_nxt   = w_win_pri;
                    w_pic_nxt   = {1'b1, VEC_BASE + 4'(w_win_idx), w_win_pri};
                end
            end
            PRESENT: begin
                if (bus.pic_read) begin
                    // Acknowledge beats a simultaneous loss of eligibility
                    w_ack_clr[r_idx] = 1'b1;
                    w_state_nxt      = ACK;
                end else if (!r_pend[r_idx] || (bus.cpu_pri >= r_pri)) begin
                    w_state_nxt = IDLE;
                end else begin
                    // Held stable: a higher-priority arrival does not preempt
                    w_pic_nxt = r_pic_in;
                end
            end
            ACK: begin
                // One cycle of deasserted pic_in before re-arbitration
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered request
    always_ff @(negedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_pic_in <= 8'h00;
            r_idx    <= '0;
            r_pri    <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_pic_in <= w_pic_nxt;
            r_idx    <= w_idx_nxt;
            r_pri    <= w_pri_nxt;
        end
    end

    assign bus.pic_in  = r_pic_in;
    assign int_pending = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_xm23_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xm23_int_ctrl
//  Description : Directed bench for xm23_int_ctrl. A second instance with
//                VEC_BASE=14 shares all inputs, so vector wrap-around is
//                exercised alongside every table vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xm23_int_ctrl;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] csr_tmr, csr_kb, csr_scr, csr_tl, csr_pb;
    logic [4:0] pend0, pend1;
    int         total = 0;
    int         bad   = 0;

    xm23_int_ctrl_if bus0 ();
    xm23_int_ctrl_if bus1 ();

    xm23_int_ctrl #(.VEC_BASE(4'd0), .NUM_DEV(5)) u_dut0 (
        .Clock(Clock), .Reset(Reset),
        .csr_tmr(csr_tmr), .csr_kb(csr_kb), .csr_scr(csr_scr),
        .csr_tl(csr_tl), .csr_pb(csr_pb),
        .bus(bus0.master), .int_pending(pend0)
    );

    xm23_int_ctrl #(.VEC_BASE(4'hE), .NUM_DEV(5)) u_dut1 (
        .Clock(Clock), .Reset(Reset),
        .csr_tmr(csr_tmr), .csr_kb(csr_kb), .csr_scr(csr_scr),
        .csr_tl(csr_tl), .csr_pb(csr_pb),
        .bus(bus1.master), .int_pending(pend1)
    );

    // Free-running clock; the DUT acts on the falling edge
    always #5 Clock = ~Clock;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] tmr, kb, scr, tl, pb;
        logic [2:0] pri;
        logic       rd;
        logic [7:0] pic;
        logic [4:0] pend;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] tmr, kb, scr, tl, pb,
                       input logic [2:0] pri, input logic rd,
                       input logic [7:0] pic, input logic [4:0] pend);
        vec_t v;
        v.tmr = tmr; v.kb = kb; v.scr = scr; v.tl = tl; v.pb = pb;
        v.pri = pri; v.rd = rd; v.pic = pic; v.pend = pend;
        tbl.push_back(v);
    endtask

    task automatic set(input logic [7:0] tmr, kb, scr, tl, pb,
                       input logic [2:0] pri, input logic rd);
        csr_tmr = tmr; csr_kb = kb; csr_scr = scr; csr_tl = tl; csr_pb = pb;
        bus0.cpu_pri = pri;  bus1.cpu_pri = pri;
        bus0.pic_read = rd;  bus1.pic_read = rd;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", nm, act, exp);
        end
    endtask

    // Expected request of the VEC_BASE=14 instance: vector shifted by 14, mod 16
    function automatic logic [7:0] wrap14(input logic [7:0] v);
        logic [3:0] vec;
        vec = v[6:3] + 4'hE;
        return v[7] ? {1'b1, vec, v[2:0]} : 8'h00;
    endfunction

    initial begin
        set(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);

        // Request byte = {valid, vector(4), priority(3)}; device i -> vector i.
        //   tmr   tkb    scr    tl     pb    cpu rd   pic    pend
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 5'b00000); // idle
        // Timer single event: A5 = pri 5, IE, DBA
        add(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 5'b00001);
        add(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h85, 5'b00001);
        add(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00, 5'b00000); // ACK
        add(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 5'b00000); // IDLE
        add(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 5'b00000); // level only
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 5'b00000);
        // Arbitration: kb pri 3 and pb pri 7 together
        add(8'h00, 8'h65, 8'h00, 8'h00, 8'hE5, 0, 0, 8'h00, 5'b10010);
        add(8'h00, 8'h65, 8'h00, 8'h00, 8'hE5, 0, 0, 8'hA7, 5'b10010); // pb: vec 4
        add(8'h00, 8'h65, 8'h00, 8'h00, 8'hE5, 0, 1, 8'h00, 5'b00010);
        add(8'h00, 8'h65, 8'h00, 8'h00, 8'hE5, 0, 0, 8'h00, 5'b00010);
        add(8'h00, 8'h65, 8'h00, 8'h00, 8'hE5, 0, 0, 8'h8B, 5'b00010); // kb: vec 1
        add(8'h00, 8'h65, 8'h00, 8'h00, 8'hE5, 0, 1, 8'h00, 5'b00000);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 5'b00000);
        // Tie-break: scr and tl both pri 4
        add(8'h00, 8'h00, 8'h85, 8'h85, 8'h00, 0, 0, 8'h00, 5'b01100);
        add(8'h00, 8'h00, 8'h85, 8'h85, 8'h00, 0, 0, 8'h94, 5'b01100);
        add(8'h00, 8'h00, 8'h85, 8'h85, 8'h00, 0, 1, 8'h00, 5'b01000);
        add(8'h00, 8'h00, 8'h85, 8'h85, 8'h00, 0, 0, 8'h00, 5'b01000);
        add(8'h00, 8'h00, 8'h85, 8'h85, 8'h00, 0, 0, 8'h9C, 5'b01000);
        add(8'h00, 8'h00, 8'h85, 8'h85, 8'h00, 0, 1, 8'h00, 5'b00000);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 5'b00000);
        // Priority masking: equal priority is not eligible
        add(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 5, 0, 8'h00, 5'b00001);
        add(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 5, 0, 8'h00, 5'b00001);
        add(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 5, 0, 8'h00, 5'b00001);
        add(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 4, 0, 8'h85, 5'b00001);
        add(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 6, 0, 8'h00, 5'b00001); // withdrawn
        add(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h85, 5'b00001);
        // Service without ack: DBA clears (A1)
        add(8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h85, 5'b00000);
        add(8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 5'b00000);
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00, 5'b00000); // read in IDLE
        add(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 8'h00, 5'b00000);

        // Asynchronous reset state
        #1 Reset = 1'b1;
        #1;
        chk("reset pic_in", bus0.pic_in, 8'h00);
        chk("reset pend", {3'b000, pend0}, 8'h00);
        @(posedge Clock);
        Reset = 1'b0;

        // Table: drive at posedge, one falling edge, check at next posedge
        for (int k = 0; k < tbl.size(); k++) begin
            set(tbl[k].tmr, tbl[k].kb, tbl[k].scr, tbl[k].tl, tbl[k].pb,
                tbl[k].pri, tbl[k].rd);
            @(posedge Clock);
            chk($sformatf("v%0d pic_in", k), bus0.pic_in, tbl[k].pic);
            chk($sformatf("v%0d pend", k), {3'b000, pend0}, {3'b000, tbl[k].pend});
            chk($sformatf("v%0d pic_in_b14", k), bus1.pic_in, wrap14(tbl[k].pic));
            chk($sformatf("v%0d pend_b14", k), {3'b000, pend1}, {3'b000, tbl[k].pend});
        end

        // Reset mid-handshake
        set(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
        @(posedge Clock);
        @(posedge Clock);
        chk("rst pre pic_in", bus0.pic_in, 8'h85);
        #2 Reset = 1'b1;
        #1;
        chk("rst async pic_in", bus0.pic_in, 8'h00);
        chk("rst async pend", {3'b000, pend0}, 8'h00);
        @(posedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        chk("rst rel pend", {3'b000, pend0}, 8'h01);
        chk("rst rel pic_in", bus0.pic_in, 8'h00);
        @(posedge Clock);
        chk("rst re-present", bus0.pic_in, 8'h85);

        // Re-trigger coinciding with the acknowledge
        set(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
        @(posedge Clock);
        chk("retrig low pic_in", bus0.pic_in, 8'h85);
        chk("retrig low pend", {3'b000, pend0}, 8'h00);
        set(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
        @(posedge Clock);
        chk("retrig ack pic_in", bus0.pic_in, 8'h00);
        chk("retrig ack pend", {3'b000, pend0}, 8'h01);
        set(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
        @(posedge Clock);
        chk("retrig idle pic_in", bus0.pic_in, 8'h00);
        @(posedge Clock);
        chk("retrig again pic_in", bus0.pic_in, 8'h85);
        set(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b1);
        @(posedge Clock);
        chk("retrig final pend", {3'b000, pend0}, 8'h00);
        set(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0);
        @(posedge Clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
